regfile_alu_pipe: RTL and testbench

REGFILE_ALU_PIPE -- requirements
Module: regfile_alu_pipe

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_alu.sv | 24 ++
 rtl/regfile_alu_pipe.sv | 119 +++++++++++
 tb/tb_regfile_alu_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared opcode encoding and default widths for the register-file ALU pipeline.
package regfile_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_t;

endpackage

// File: rtl/regfile_alu.sv
// Purely combinational ALU; every result wraps modulo 2**DATA_WIDTH with no flags.
import regfile_pkg::*;

module regfile_alu #(
  parameter int DATA_WIDTH = DATA_W_DEF
) (
  input  op_t                   op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/regfile_alu_pipe.sv
// Two-stage operand-latch / result-latch ALU pipeline in front of an external register file.
// Handshake: a beat transfers on an edge where valid && ready; a producer holding valid keeps its payload stable.
import regfile_pkg::*;

module regfile_alu_pipe #(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  op_t                   op,
  input  logic [ADDR_WIDTH-1:0] src0,
  input  logic [ADDR_WIDTH-1:0] src1,
  input  logic [ADDR_WIDTH-1:0] dst,
  output logic [ADDR_WIDTH-1:0] r_addr0,
  output logic [ADDR_WIDTH-1:0] r_addr1,
  input  logic [DATA_WIDTH-1:0] r_data0,
  input  logic [DATA_WIDTH-1:0] r_data1,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  write_enable,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_dst
);

  logic                  s1_valid_q, s1_valid_d;
  op_t                   s1_op_q, s1_op_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [ADDR_WIDTH-1:0] s1_dst_q, s1_dst_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
  logic [ADDR_WIDTH-1:0] s2_dst_q, s2_dst_d;

  logic                  s2_free;
  logic [DATA_WIDTH-1:0] alu_y, fwd0, fwd1;

  regfile_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op_i (s1_op_q),
    .a_i  (s1_a_q),
    .b_i  (s1_b_q),
    .y_o  (alu_y)
  );

  assign r_addr0  = src0;
  assign r_addr1  = src1;
  assign s2_free  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;

  assign out_valid    = s2_valid_q;
  assign out_data     = s2_data_q;
  assign out_dst      = s2_dst_q;
  assign write_enable = s2_valid_q && out_ready;
  assign w_addr       = s2_dst_q;
  assign w_data       = s2_data_q;

  // The youngest producer wins: S1 has not written yet, S2 writes only at this edge.
  always_comb begin
    fwd0 = r_data0;
    fwd1 = r_data1;
    if (s1_valid_q && s1_dst_q == src0)      fwd0 = alu_y;
    else if (s2_valid_q && s2_dst_q == src0) fwd0 = s2_data_q;
    if (s1_valid_q && s1_dst_q == src1)      fwd1 = alu_y;
    else if (s2_valid_q && s2_dst_q == src1) fwd1 = s2_data_q;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_dst_d   = s1_dst_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_dst_d   = s2_dst_q;
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = alu_y;
        s2_dst_d  = s1_dst_q;
      end
    end
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d  = op;
        s1_a_d   = fwd0;
        s1_b_d   = fwd1;
        s1_dst_d = dst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_ADD;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_dst_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_dst_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_dst_q   <= s1_dst_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_dst_q   <= s2_dst_d;
    end
  end

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Directed bench for regfile_alu_pipe with a behavioural 8x8 register file attached.
import regfile_pkg::*;

module tb_regfile_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  op_t        op;
  logic [2:0] src0, src1, dst;
  logic [2:0] r_addr0, r_addr1;
  logic [7:0] r_data0, r_data1;
  logic [2:0] w_addr;
  logic [7:0] w_data;
  logic       write_enable;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_dst;

  logic [7:0] ram [8];
  int         wr_cnt = 0;
  int         passed = 0;
  int         total  = 0;
  int         w0;

  always #5 clk = ~clk;

  regfile_alu_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .src0         (src0),
    .src1         (src1),
    .dst          (dst),
    .r_addr0      (r_addr0),
    .r_addr1      (r_addr1),
    .r_data0      (r_data0),
    .r_data1      (r_data1),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .write_enable (write_enable),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_dst      (out_dst)
  );

  assign r_data0 = ram[r_addr0];
  assign r_data1 = ram[r_addr1];

  always @(posedge clk) begin
    if (write_enable) begin
      ram[w_addr] <= w_data;
      wr_cnt      <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input op_t o, input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
    in_valid = 1'b1;
    op       = o;
    dst      = d;
    src0     = a;
    src1     = b;
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    #1;
  endtask

  task automatic run_alu(input string tag, input op_t o, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp);
    ram[5] = a;
    ram[6] = b;
    issue(o, 3'd7, 3'd5, 3'd6);
    tick();
    idle();
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ram[i] = 8'h00;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = OP_ADD; src0 = '0; src1 = '0; dst = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_dst", out_dst, 0);
    chk("rst_in_ready", in_ready, 1);

    // Single ADD with latency 2
    ram[1] = 8'd5;
    ram[2] = 8'd3;
    issue(OP_ADD, 3'd3, 3'd1, 3'd2);
    chk("raddr0", r_addr0, 1);
    chk("raddr1", r_addr1, 2);
    tick();
    idle();
    chk("add_lat1_valid", out_valid, 0);
    tick();
    chk("add_valid", out_valid, 1);
    chk("add_data", out_data, 8);
    chk("add_dst", out_dst, 3);
    chk("add_we", write_enable, 1);
    chk("add_waddr", w_addr, 3);
    chk("add_wdata", w_data, 8);
    tick();
    chk("add_done", out_valid, 0);
    chk("add_ram3", ram[3], 8);

    // Back-to-back dependent pair, S1 forwarding
    ram[3] = 8'h00;
    issue(OP_ADD, 3'd3, 3'd1, 3'd2);
    tick();
    issue(OP_SUB, 3'd4, 3'd3, 3'd1);
    chk("b2b_in_ready", in_ready, 1);
    tick();
    idle();
    chk("b2b_first_data", out_data, 8);
    chk("b2b_first_dst", out_dst, 3);
    tick();
    chk("b2b_second_valid", out_valid, 1);
    chk("b2b_second_data", out_data, 3);
    chk("b2b_second_dst", out_dst, 4);
    tick();
    chk("b2b_ram4", ram[4], 3);

    // ALU wraparound and logic ops
    run_alu("add_wrap", OP_ADD, 8'd200, 8'd100, 8'd44);
    run_alu("sub_wrap", OP_SUB, 8'd0, 8'd1, 8'd255);
    run_alu("and", OP_AND, 8'hF0, 8'h3C, 8'h30);
    run_alu("xor", OP_XOR, 8'hFF, 8'h0F, 8'hF0);

    // Backpressure: both stages fill, then drain in order
    ram[1] = 8'd5;
    ram[2] = 8'd3;
    out_ready = 1'b0;
    issue(OP_ADD, 3'd5, 3'd1, 3'd2);
    chk("bp_ready0", in_ready, 1);
    tick();
    issue(OP_SUB, 3'd6, 3'd1, 3'd2);
    chk("bp_ready1", in_ready, 1);
    tick();
    issue(OP_XOR, 3'd7, 3'd1, 3'd2);
    chk("bp_ready_low", in_ready, 0);
    chk("bp_we_low", write_enable, 0);
    chk("bp_data_a", out_data, 8);
    tick();
    chk("bp_data_b", out_data, 8);
    chk("bp_dst_b", out_dst, 5);
    chk("bp_ready_low2", in_ready, 0);
    tick();
    chk("bp_data_c", out_data, 8);
    chk("bp_we_low2", write_enable, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_we", write_enable, 1);
    tick();
    idle();
    chk("bp_r2_data", out_data, 2);
    chk("bp_r2_dst", out_dst, 6);
    tick();
    chk("bp_r3_data", out_data, 6);
    chk("bp_r3_dst", out_dst, 7);
    tick();
    chk("bp_drained", out_valid, 0);

    // S1 and S2 both target r4; S1 must win for both operands
    ram[5] = 8'd7;
    ram[6] = 8'd9;
    issue(OP_ADD, 3'd4, 3'd5, 3'd0);
    tick();
    issue(OP_ADD, 3'd4, 3'd6, 3'd0);
    tick();
    issue(OP_ADD, 3'd3, 3'd4, 3'd4);
    chk("prio_s2_data", out_data, 7);
    tick();
    idle();
    chk("prio_s2b_data", out_data, 9);
    tick();
    chk("prio_data", out_data, 8'd18);
    chk("prio_dst", out_dst, 3);
    tick();

    // Reset with both stages full discards them
    out_ready = 1'b0;
    issue(OP_ADD, 3'd5, 3'd1, 3'd2);
    tick();
    issue(OP_SUB, 3'd6, 3'd1, 3'd2);
    tick();
    idle();
    chk("full_ready_low", in_ready, 0);
    w0 = wr_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_we", write_enable, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_wr_cnt", wr_cnt, w0);
    out_ready = 1'b1;
    issue(OP_ADD, 3'd3, 3'd1, 3'd2);
    tick();
    idle();
    chk("post_rst_s1_only", out_valid, 0);
    tick();
    chk("post_rst_data", out_data, 8);
    chk("post_rst_dst", out_dst, 3);
    chk("post_rst_we", write_enable, 1);
    tick();
    chk("post_rst_wr_cnt", wr_cnt, w0 + 1);
    chk("post_rst_ram6", ram[6], 9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
